// File: rtl/unpacked_stream_seq_if.sv
// Stream bundle: packed-frame input handshake plus element output handshake.
// The DUT side takes the slave modport; the frame producer/element consumer takes master.
interface unpacked_stream_seq_if #(
   parameter int ELEM_W   = 4,
   parameter int NUM_ELEM = 5
);
   localparam int IDX_W = $clog2(NUM_ELEM);

   logic                       in_valid;
   logic                       in_ready;
   logic [ELEM_W*NUM_ELEM-1:0] in_data;
   logic                       in_rev;
   logic                       out_valid;
   logic                       out_ready;
   logic [ELEM_W-1:0]          out_elem;
   logic [IDX_W-1:0]           out_idx;
   logic                       out_last;

   modport slave (
      input  in_valid, in_data, in_rev, out_ready,
      output in_ready, out_valid, out_elem, out_idx, out_last
   );

   modport master (
      output in_valid, in_data, in_rev, out_ready,
      input  in_ready, out_valid, out_elem, out_idx, out_last
   );
endinterface

// File: rtl/unpacked_stream_seq.sv
// Registers a packed frame and emits its elements one per cycle, first element the cycle after accept.
// Elements stall while out_ready is low; a new frame is taken only when idle or on the last handshake.
module unpacked_stream_seq #(
   parameter int ELEM_W   = 4,
   parameter int NUM_ELEM = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  abort,
   output logic                  busy,
   unpacked_stream_seq_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_ELEM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);
   localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] STREAM = 1'b1;

   logic [0:0]        state_q;
   logic [ELEM_W-1:0] frame_q [NUM_ELEM];
   logic              rev_q;
   logic [IDX_W-1:0]  idx_q;
   logic              hs;
   logic              accept;

   assign bus.out_valid = (state_q == STREAM);
   assign busy          = (state_q == STREAM);
   assign bus.out_elem  = frame_q[idx_q];
   assign bus.out_idx   = idx_q;
   // The terminal index depends on the direction latched with the frame.
   assign bus.out_last  = bus.out_valid && (rev_q ? (idx_q == '0) : (idx_q == LAST_IDX));

   assign hs           = bus.out_valid && bus.out_ready;
   assign bus.in_ready = !abort && ((state_q == IDLE) || (hs && bus.out_last));
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rev_q   <= 1'b0;
         idx_q   <= '0;
         for (int i = 0; i < NUM_ELEM; i++) begin
            frame_q[i] <= '0;
         end
      end else if (abort) begin
         state_q <= IDLE;
      end else if (accept) begin
         // Element 0 is the most-significant slice, as a packed-to-unpacked cast would give.
         for (int i = 0; i < NUM_ELEM; i++) begin
            frame_q[i] <= bus.in_data[ELEM_W*(NUM_ELEM-i)-1 -: ELEM_W];
         end
         rev_q   <= bus.in_rev;
         idx_q   <= bus.in_rev ? LAST_IDX : '0;
         state_q <= STREAM;
      end else if (hs) begin
         if (bus.out_last) begin
            state_q <= IDLE;
         end else begin
            idx_q <= rev_q ? (idx_q - ONE) : (idx_q + ONE);
         end
      end
   end
endmodule

// File: tb/tb_unpacked_stream_seq.sv
// Scoreboard bench: every accepted frame is expanded into its expected element list;
// a monitor compares the presented element against the queue head each cycle.
module tb_unpacked_stream_seq;
   localparam int W  = 4;
   localparam int N  = 5;
   localparam int DW = W * N;

   typedef struct {
      int elem;
      int idx;
      bit last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic abort;
   logic busy;

   int total = 0;
   int bad   = 0;
   exp_t q[$];

   unpacked_stream_seq_if #(.ELEM_W(W), .NUM_ELEM(N)) bus ();

   unpacked_stream_seq #(.ELEM_W(W), .NUM_ELEM(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .abort (abort),
      .busy  (busy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push_frame(input logic [DW-1:0] d, input bit r);
      for (int k = 0; k < N; k++) begin
         int   i;
         exp_t e;
         i      = r ? (N - 1 - k) : k;
         e.idx  = i;
         e.elem = int'((d >> (W * (N - 1 - i))) & ((1 << W) - 1));
         e.last = (k == N - 1);
         q.push_back(e);
      end
   endfunction

   // One clock of stimulus; the model decides acceptance from the queue contents alone.
   task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r,
                        input bit ordy, input bit ab, output bit acc);
      bit exp_rdy;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_rev    = r;
      bus.out_ready = ordy;
      abort         = ab;
      #1;
      exp_rdy = !ab && (q.size() == 0 || (ordy && q.size() == 1));
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
      acc = v && exp_rdy;
      @(posedge clk);
      if (ab) q.delete();
      else if (acc) push_frame(d, r);
   endtask

   task automatic send(input logic [DW-1:0] d, input bit r);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 40) begin
         cycle(1'b1, d, r, 1'b1, 1'b0, acc);
         n++;
      end
      if (!acc) chk("send_timeout", 32'(n), 32'(0));
   endtask

   task automatic idle(input int cnt, input bit ordy);
      bit acc;
      for (int i = 0; i < cnt; i++) cycle(1'b0, DW'($urandom), 1'b0, ordy, 1'b0, acc);
   endtask

   // Monitor: compares outputs with the scoreboard head, pops on each observed handshake.
   initial begin
      bit hs_s;
      forever begin
         @(negedge clk);
         #1;
         hs_s = 1'b0;
         if (rst_n === 1'b1) begin
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
            chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
            if (q.size() != 0 && bus.out_valid === 1'b1) begin
               chk("out_elem", {28'b0, bus.out_elem}, q[0].elem);
               chk("out_idx", {29'b0, bus.out_idx}, q[0].idx);
               chk("out_last", {31'b0, bus.out_last}, {31'b0, q[0].last});
            end
            hs_s = bus.out_valid && bus.out_ready && !abort;
         end
         @(posedge clk);
         if (hs_s && q.size() != 0 && rst_n === 1'b1) void'(q.pop_front());
      end
   end

   initial begin
      bit acc;
      bit pend;
      bit ab;
      bit ordy;
      bit r;
      logic [DW-1:0] d;

      rst_n         = 1'b0;
      abort         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_rev    = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_out_last", {31'b0, bus.out_last}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_out_elem", {28'b0, bus.out_elem}, 32'd0);
      chk("rst_out_idx", {29'b0, bus.out_idx}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Forward and reverse order
      send(20'h12345, 1'b0);
      idle(6, 1'b1);
      send(20'h12345, 1'b1);
      idle(6, 1'b1);

      // Backpressure on the second element
      send(20'h12345, 1'b0);
      idle(1, 1'b1);
      idle(3, 1'b0);
      idle(6, 1'b1);

      // Back-to-back frames, no bubble
      send(20'hABCDE, 1'b0);
      send(20'h01234, 1'b0);
      idle(7, 1'b1);

      // Abort while the third element is presented; a frame offered then must be refused
      send(20'h12345, 1'b0);
      idle(2, 1'b1);
      cycle(1'b1, 20'h99999, 1'b0, 1'b1, 1'b1, acc);
      chk("abort_no_accept", {31'b0, acc}, 32'd0);
      send(20'hFEDCB, 1'b0);
      idle(6, 1'b1);

      // Abort in idle only blocks acceptance for that cycle
      cycle(1'b0, 20'h55555, 1'b0, 1'b1, 1'b1, acc);
      idle(2, 1'b1);

      // Reset mid-frame
      send(20'h12345, 1'b0);
      idle(1, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_out_idx", {29'b0, bus.out_idx}, 32'd0);
      chk("midrst_out_elem", {28'b0, bus.out_elem}, 32'd0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(20'h12345, 1'b0);
      idle(6, 1'b1);

      // Randomized traffic with backpressure, aborts and direction changes
      pend = 1'b0;
      d    = '0;
      r    = 1'b0;
      repeat (800) begin
         if (!pend) begin
            pend = ($urandom_range(0, 2) != 0);
            d    = DW'($urandom);
            r    = 1'($urandom_range(0, 1));
         end
         ab   = ($urandom_range(0, 24) == 0);
         ordy = ($urandom_range(0, 3) != 0);
         cycle(pend, pend ? d : DW'($urandom), r, ordy, ab, acc);
         if (acc) pend = 1'b0;
      end
      idle(12, 1'b1);
      chk("drain_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/unpacked_stream_seq.md
UNPACKED_STREAM_SEQ -- requirements
Module: unpacked_stream_seq

Interface
REQ-001: Parameter ELEM_W, default 4, SHALL set the element width in bits.
REQ-002: Parameter NUM_ELEM, default 5, SHALL set the number of elements per frame (minimum 2).
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005: in_valid  input  1  SHALL indicate that a packed frame is offered.
REQ-006: in_ready  output  1  SHALL indicate that the block accepts a frame this cycle.
REQ-007: in_data  input  ELEM_W*NUM_ELEM  SHALL carry the packed frame.
REQ-008: in_rev  input  1  SHALL select the emit order, sampled with the frame (0 = left-to-right, 1 = right-to-left).
REQ-009: abort  input  1  SHALL synchronously cancel the frame in progress.
REQ-010: out_valid  output  1  SHALL indicate that out_elem holds a valid element.
REQ-011: out_ready  input  1  SHALL indicate that the consumer accepts out_elem this cycle.
REQ-012: out_elem  output  ELEM_W  SHALL carry the current element.
REQ-013: out_idx  output  $clog2(NUM_ELEM)  SHALL carry the unpacked-array index of out_elem.
REQ-014: out_last  output  1  SHALL mark the final element of the frame.
REQ-015: busy  output  1  SHALL be high whenever the state is STREAM.

Function
REQ-016: Element i of a frame SHALL be in_data[ELEM_W*(NUM_ELEM-i)-1 -: ELEM_W], so element 0 is the most-significant slice, matching a packed-to-unpacked cast.
REQ-017: The block SHALL register the whole frame and in_rev when in_valid && in_ready (the accept).
REQ-018: The FSM SHALL have two states, IDLE and STREAM; the accept moves it to STREAM, and an out handshake with out_last set and no new accept moves it to IDLE.
REQ-019: in_ready SHALL equal !abort && (state==IDLE || (out_valid && out_ready && out_last)).
REQ-020: out_valid SHALL be high from the cycle after the accept until the last element handshakes, or until abort.
REQ-021: With in_rev=0, elements SHALL be emitted with out_idx 0,1,...,NUM_ELEM-1; with in_rev=1, with out_idx NUM_ELEM-1,...,0.
REQ-022: An element SHALL advance only on out_valid && out_ready; otherwise out_elem, out_idx and out_last SHALL hold stable.
REQ-023: out_last SHALL be high only while the final element of the frame (per in_rev) is presented.
REQ-024: When the last element handshakes and a new frame is accepted in the same cycle, element 0 of the new frame (or NUM_ELEM-1 if reversed) SHALL appear the next cycle, with no bubble.
REQ-025: abort SHALL take priority over both load and handshake: the next cycle the state is IDLE, out_valid=0 and no frame is accepted in the abort cycle.
REQ-026: abort while in IDLE SHALL have no effect other than forcing in_ready low for that cycle.
REQ-027: in_data changes while out_valid is high SHALL NOT affect the emitted elements.
REQ-028: Sustained throughput SHALL be one element per cycle when out_ready is held high.

Reset
REQ-029: While rst_n=0, state SHALL be IDLE, and out_valid, out_last and busy SHALL be 0.
REQ-030: While rst_n=0, out_elem and out_idx SHALL be 0 and the frame register SHALL be cleared.
REQ-031: Reset asserted mid-frame SHALL discard the frame immediately (asynchronously).
REQ-032: After rst_n rises, in_ready SHALL be 1 in the first cycle, provided abort=0.

Verification
REQ-033: Forward order: in_data=20'h12345, in_rev=0, out_ready=1 -> out_elem 1,2,3,4,5 on 5 consecutive cycles; out_idx 0..4; out_last only on 5.
REQ-034: Reverse order: in_data=20'h12345, in_rev=1 -> out_elem 5,4,3,2,1; out_idx 4..0; out_last on 1.
REQ-035: Backpressure: out_ready low for 3 cycles while elem 2 is presented -> out_elem=2, out_idx=1 held stable; the sequence resumes with 3.
REQ-036: Back-to-back: frames 20'hABCDE then 20'h01234 with in_valid held high and out_ready=1 -> 10 consecutive valid cycles A,B,C,D,E,0,1,2,3,4; in_ready high on the E cycle.
REQ-037: Abort: abort pulsed while elem 3 of 20'h12345 is presented -> out_valid=0 and busy=0 next cycle; the following frame 20'hFEDCB emits F first.
REQ-038: Reset mid-frame: rst_n low while elem 2 is presented -> out_valid=0 immediately; after release, in_ready=1 and the next frame starts at element 0.
